// File: rtl/rv32i_pipelined_core.sv
// Five-stage in-order RV32I core (IF, ID, EX, MEM, WB) with full forwarding,
// a one-cycle load-use stall, and taken branches/jumps resolved in EX.
module rv32i_pipelined_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_if,
    output logic        mem_wr_en,
    output logic [2:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);
    typedef enum logic [2:0] {
        MEM_B = 3'b000, MEM_H = 3'b001, MEM_W = 3'b010, MEM_BU = 3'b100, MEM_HU = 3'b101
    } mem_op_t;

    localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6f, OPC_JALR = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63, OPC_LOAD = 7'h03, OPC_STORE = 7'h23;
    localparam logic [6:0] OPC_IMM = 7'h13, OPC_REG = 7'h33;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] pc;
    logic [31:0] ifid_instr, ifid_pc;
    logic [6:0]  idex_opcode;
    logic [2:0]  idex_f3;
    logic        idex_f7b5;
    logic [4:0]  idex_rd, idex_rs1, idex_rs2;
    logic [31:0] idex_pc, idex_imm, idex_rs1v, idex_rs2v;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result, exmem_sdata;
    logic        exmem_wr, exmem_load;
    mem_op_t     exmem_op;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic [31:0] regs [NUM_REGS];

    // ID: decode, immediates, write-through register read
    logic [6:0]  id_opcode;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic [31:0] id_imm, id_rs1v, id_rs2v;
    logic        id_uses_rs1, id_uses_rs2;

    assign id_opcode = ifid_instr[6:0];
    assign id_rd     = ifid_instr[11:7];
    assign id_rs1    = ifid_instr[19:15];
    assign id_rs2    = ifid_instr[24:20];
    assign id_uses_rs1 = !(id_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    assign id_uses_rs2 = id_opcode inside {OPC_REG, OPC_STORE, OPC_BRANCH};

    always_comb begin
        id_imm = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
        case (id_opcode)
            OPC_STORE:          id_imm = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
            OPC_BRANCH:         id_imm = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                                          ifid_instr[30:25], ifid_instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: id_imm = {ifid_instr[31:12], 12'b0};
            OPC_JAL:            id_imm = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                                          ifid_instr[20], ifid_instr[30:21], 1'b0};
            default:            id_imm = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
        endcase
    end

    always_comb begin
        id_rs1v = (id_rs1 == 5'd0) ? 32'd0 : (memwb_rd == id_rs1) ? memwb_result : regs[id_rs1];
        id_rs2v = (id_rs2 == 5'd0) ? 32'd0 : (memwb_rd == id_rs2) ? memwb_result : regs[id_rs2];
    end

    // EX: forwarding (MEM stage beats WB stage), ALU, branch resolution
    logic [31:0] ex_a, ex_b_reg, ex_b, ex_alu, ex_addr, ex_result, ex_target;
    logic        ex_wr, ex_take, ex_redirect, ld_stall;

    always_comb begin
        ex_a = idex_rs1v;
        if (exmem_rd != 5'd0 && exmem_rd == idex_rs1)      ex_a = exmem_result;
        else if (memwb_rd != 5'd0 && memwb_rd == idex_rs1) ex_a = memwb_result;
        ex_b_reg = idex_rs2v;
        if (exmem_rd != 5'd0 && exmem_rd == idex_rs2)      ex_b_reg = exmem_result;
        else if (memwb_rd != 5'd0 && memwb_rd == idex_rs2) ex_b_reg = memwb_result;
    end

    assign ex_b    = (idex_opcode == OPC_REG) ? ex_b_reg : idex_imm;
    assign ex_addr = ex_a + idex_imm;

    always_comb begin
        case (idex_f3)
            3'b000:  ex_alu = (idex_opcode == OPC_REG && idex_f7b5) ? ex_a - ex_b : ex_a + ex_b;
            3'b001:  ex_alu = ex_a << ex_b[4:0];
            3'b010:  ex_alu = {31'b0, $signed(ex_a) < $signed(ex_b)};
            3'b011:  ex_alu = {31'b0, ex_a < ex_b};
            3'b100:  ex_alu = ex_a ^ ex_b;
            3'b101:  ex_alu = idex_f7b5 ? 32'($signed(ex_a) >>> ex_b[4:0]) : ex_a >> ex_b[4:0];
            3'b110:  ex_alu = ex_a | ex_b;
            default: ex_alu = ex_a & ex_b;
        endcase
    end

    always_comb begin
        case (idex_opcode)
            OPC_LUI:           ex_result = idex_imm;
            OPC_AUIPC:         ex_result = idex_pc + idex_imm;
            OPC_JAL, OPC_JALR: ex_result = idex_pc + 32'd4;
            OPC_IMM, OPC_REG:  ex_result = ex_alu;
            default:           ex_result = ex_addr;
        endcase
        case (idex_f3)
            3'b000:  ex_take = (ex_a == ex_b_reg);
            3'b001:  ex_take = (ex_a != ex_b_reg);
            3'b100:  ex_take = ($signed(ex_a) < $signed(ex_b_reg));
            3'b101:  ex_take = ($signed(ex_a) >= $signed(ex_b_reg));
            3'b110:  ex_take = (ex_a < ex_b_reg);
            3'b111:  ex_take = (ex_a >= ex_b_reg);
            default: ex_take = 1'b0;
        endcase
    end

    // Unknown, FENCE and SYSTEM opcodes fall out of ex_wr and behave as NOPs
    assign ex_wr = idex_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_IMM, OPC_REG};
    assign ex_redirect = (idex_opcode == OPC_BRANCH && ex_take) ||
                         idex_opcode == OPC_JAL || idex_opcode == OPC_JALR;
    assign ex_target = (idex_opcode == OPC_JALR) ? {ex_addr[31:1], 1'b0} : idex_pc + idex_imm;
    assign ld_stall  = idex_opcode == OPC_LOAD && idex_rd != 5'd0 &&
                       ((id_uses_rs1 && id_rs1 == idex_rd) || (id_uses_rs2 && id_rs2 == idex_rd));

    always_ff @(posedge clk) begin
        if (resetn) begin
            pc           <= RESET_PC;
            ifid_instr   <= NOP;
            ifid_pc      <= '0;
            idex_opcode  <= OPC_IMM;
            idex_f3      <= '0;
            idex_f7b5    <= 1'b0;
            idex_rd      <= '0;
            idex_rs1     <= '0;
            idex_rs2     <= '0;
            idex_pc      <= '0;
            idex_imm     <= '0;
            idex_rs1v    <= '0;
            idex_rs2v    <= '0;
            exmem_rd     <= '0;
            exmem_result <= '0;
            exmem_sdata  <= '0;
            exmem_wr     <= 1'b0;
            exmem_load   <= 1'b0;
            exmem_op     <= MEM_W;
            memwb_rd     <= '0;
            memwb_result <= '0;
        end else begin
            exmem_rd     <= ex_wr ? idex_rd : 5'd0;
            exmem_result <= ex_result;
            exmem_sdata  <= (idex_opcode == OPC_STORE) ? ex_b_reg : 32'd0;
            exmem_wr     <= (idex_opcode == OPC_STORE);
            exmem_load   <= (idex_opcode == OPC_LOAD);
            exmem_op     <= (idex_opcode inside {OPC_LOAD, OPC_STORE}) ? mem_op_t'(idex_f3) : MEM_W;
            memwb_rd     <= exmem_rd;
            memwb_result <= exmem_load ? mem_data_out : exmem_result;
            if (ex_redirect) begin
                pc          <= ex_target;
                ifid_instr  <= NOP;
                idex_opcode <= OPC_IMM;
                idex_rd     <= '0;
            end else if (ld_stall) begin
                idex_opcode <= OPC_IMM;
                idex_rd     <= '0;
            end else begin
                pc          <= pc + 32'd4;
                ifid_instr  <= instr_if;
                ifid_pc     <= pc;
                idex_opcode <= id_opcode;
                idex_f3     <= ifid_instr[14:12];
                idex_f7b5   <= ifid_instr[30];
                idex_rd     <= id_rd;
                idex_rs1    <= id_rs1;
                idex_rs2    <= id_rs2;
                idex_pc     <= ifid_pc;
                idex_imm    <= id_imm;
                idex_rs1v   <= id_rs1v;
                idex_rs2v   <= id_rs2v;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (memwb_rd != 5'd0) begin
            regs[memwb_rd] <= memwb_result;
        end
    end

    assign pc_out      = pc;
    assign mem_wr_en   = exmem_wr & ~resetn;
    assign mem_op      = exmem_op;
    assign mem_addr    = exmem_result;
    assign mem_data_in = exmem_sdata;
endmodule

// File: tb/tb_rv32i_pipelined_core.sv
// Bench for rv32i_pipelined_core: small programs in a ROM, every store checked
// against a queue of expected writes (address, data, size, and cycle where it matters).
module tb_rv32i_pipelined_core;
    logic        clk;
    logic        resetn;
    logic [31:0] pc_out, instr_if, mem_addr, mem_data_in, mem_data_out;
    logic        mem_wr_en;
    logic [2:0]  mem_op;

    rv32i_pipelined_core dut (
        .clk(clk), .resetn(resetn), .pc_out(pc_out), .instr_if(instr_if),
        .mem_wr_en(mem_wr_en), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rom [64];
    logic [7:0]  ram [1024];
    logic [9:0]  ra;
    assign instr_if = rom[pc_out[7:2]];
    assign ra = mem_addr[9:0];

    always_comb begin
        case (mem_op)
            3'b000:  mem_data_out = {{24{ram[ra][7]}}, ram[ra]};
            3'b001:  mem_data_out = {{16{ram[10'(ra + 1)][7]}}, ram[10'(ra + 1)], ram[ra]};
            3'b100:  mem_data_out = {24'd0, ram[ra]};
            3'b101:  mem_data_out = {16'd0, ram[10'(ra + 1)], ram[ra]};
            default: mem_data_out = {ram[10'(ra + 3)], ram[10'(ra + 2)], ram[10'(ra + 1)], ram[ra]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_wr_en) begin
            ram[ra] <= mem_data_in[7:0];
            if (mem_op[1:0] != 2'b00) ram[10'(ra + 1)] <= mem_data_in[15:8];
            if (mem_op[1]) begin
                ram[10'(ra + 2)] <= mem_data_in[23:16];
                ram[10'(ra + 3)] <= mem_data_in[31:24];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // cycle-check mode: 0 ignore, 1 exact cycle, 2 no later than cyc
    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  op;
        int          cyc;
        int          mode;
    } wr_t;
    wr_t sb_q[$];

    task automatic expect_wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] op, input int cyc, input int mode);
        wr_t e;
        e.tag = tag; e.addr = a; e.data = d; e.op = op; e.cyc = cyc; e.mode = mode;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] size_mask(input logic [2:0] op);
        case (op[1:0])
            2'b00:   return 32'h0000_00ff;
            2'b01:   return 32'h0000_ffff;
            default: return 32'hffff_ffff;
        endcase
    endfunction

    // posedges since reset release; instruction k is in IF when cyc == k
    int cyc;
    always @(posedge clk) begin
        if (resetn) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!resetn && mem_wr_en) begin
            check_eq("write_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                wr_t e;
                e = sb_q.pop_front();
                check_eq({e.tag, "_addr"}, mem_addr, e.addr);
                check_eq({e.tag, "_data"}, mem_data_in & size_mask(mem_op), e.data);
                check_eq({e.tag, "_op"}, {29'd0, mem_op}, {29'd0, e.op});
                if (e.mode == 1)      check_eq({e.tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
                else if (e.mode == 2) check_eq({e.tag, "_in_budget"}, 32'(cyc <= e.cyc), 32'd1);
            end
        end
    end

    function automatic logic [31:0] i_type(input logic [6:0] op, input logic [4:0] rd,
                                           input logic [2:0] f3, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return i_type(7'h13, rd, 3'd0, rs1, imm);
    endfunction
    function automatic logic [31:0] load(input logic [2:0] f3, input logic [4:0] rd, input logic [11:0] imm);
        return i_type(7'h03, rd, f3, 5'd0, imm);
    endfunction
    function automatic logic [31:0] store(input logic [2:0] f3, input logic [4:0] rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, 5'd0, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] b_type(input logic [2:0] f3, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] j_type(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    task automatic begin_test();
        resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 64; i++) rom[i] = j_type(5'd0, 21'd0);
    endtask

    task automatic finish_test(input string name);
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        check_eq({name, "_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        resetn = 1'b1;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;

        // ALU chain with forwarding into ALU operands and store data, no stalls
        begin_test();
        rom[0] = addi(5'd1, 5'd0, 12'd5);
        rom[1] = addi(5'd2, 5'd1, 12'd7);
        rom[2] = r_type(7'h00, 3'd0, 5'd3, 5'd1, 5'd2);
        rom[3] = store(3'd2, 5'd3, 12'd512);
        expect_wr("alu_fwd", 32'd512, 32'h11, 3'd2, 6, 1);
        repeat (2) @(negedge clk);
        check_eq("rst_pc", pc_out, 32'd0);
        check_eq("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_wdata", mem_data_in, 32'd0);
        check_eq("rst_op", {29'd0, mem_op}, 32'd2);
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("pc_seq", pc_out, 32'(4 * i));
            @(negedge clk);
        end
        finish_test("alu_fwd");

        // register file cleared by reset, then a load-use pair costing one bubble
        begin_test();
        rom[0] = store(3'd2, 5'd3, 12'd600);
        rom[1] = addi(5'd6, 5'd0, 12'h069);
        rom[2] = store(3'd2, 5'd6, 12'd512);
        rom[3] = load(3'd2, 5'd4, 12'd512);
        rom[4] = addi(5'd5, 5'd4, 12'd1);
        rom[5] = store(3'd2, 5'd5, 12'd516);
        expect_wr("rf_cleared", 32'd600, 32'h0, 3'd2, 3, 1);
        expect_wr("st_69", 32'd512, 32'h69, 3'd2, 5, 1);
        expect_wr("load_use", 32'd516, 32'h6a, 3'd2, 9, 1);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        finish_test("load_use");

        // sub-word loads with sign/zero extension, and a halfword store
        begin_test();
        rom[0] = addi(5'd7, 5'd0, 12'hf80);
        rom[1] = store(3'd2, 5'd7, 12'd520);
        rom[2] = load(3'd0, 5'd8, 12'd520);
        rom[3] = store(3'd2, 5'd8, 12'd524);
        rom[4] = load(3'd4, 5'd9, 12'd520);
        rom[5] = store(3'd2, 5'd9, 12'd528);
        rom[6] = load(3'd5, 5'd10, 12'd520);
        rom[7] = store(3'd2, 5'd10, 12'd532);
        rom[8] = load(3'd1, 5'd11, 12'd520);
        rom[9] = store(3'd1, 5'd11, 12'd536);
        expect_wr("sw_neg", 32'd520, 32'hffff_ff80, 3'd2, 0, 0);
        expect_wr("lb", 32'd524, 32'hffff_ff80, 3'd2, 0, 0);
        expect_wr("lbu", 32'd528, 32'h0000_0080, 3'd2, 0, 0);
        expect_wr("lhu", 32'd532, 32'h0000_ff80, 3'd2, 0, 0);
        expect_wr("lh_sh", 32'd536, 32'h0000_ff80, 3'd1, 0, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        finish_test("subword");

        // branch loop, forward beq skipping stores, jal/jalr call and x0 hardwiring;
        // every shadow slot after a taken control transfer holds a store that must not fire
        begin_test();
        rom[0]  = addi(5'd1, 5'd0, 12'd0);
        rom[1]  = addi(5'd2, 5'd0, 12'd1);
        rom[2]  = addi(5'd3, 5'd0, 12'd15);
        rom[3]  = r_type(7'h00, 3'd0, 5'd1, 5'd1, 5'd2);
        rom[4]  = addi(5'd2, 5'd2, 12'd1);
        rom[5]  = b_type(3'd1, 5'd2, 5'd3, 13'h1ff8);
        rom[6]  = store(3'd0, 5'd1, 12'd512);
        rom[7]  = addi(5'd1, 5'd0, 12'd0);
        rom[8]  = b_type(3'd0, 5'd0, 5'd0, 13'd12);
        rom[9]  = store(3'd2, 5'd0, 12'd516);
        rom[10] = store(3'd2, 5'd0, 12'd520);
        rom[11] = j_type(5'd1, 21'd24);
        rom[12] = store(3'd2, 5'd1, 12'd540);
        rom[13] = addi(5'd0, 5'd0, 12'd1);
        rom[14] = store(3'd2, 5'd0, 12'd544);
        rom[15] = j_type(5'd0, 21'd0);
        rom[16] = 32'h0000_0013;
        rom[17] = addi(5'd5, 5'd0, 12'h033);
        rom[18] = store(3'd2, 5'd5, 12'd548);
        rom[19] = i_type(7'h67, 5'd0, 3'd0, 5'd1, 12'd0);
        rom[20] = store(3'd2, 5'd0, 12'd552);
        rom[21] = store(3'd2, 5'd0, 12'd556);
        expect_wr("loop_sum", 32'd512, 32'h69, 3'd0, 100, 2);
        expect_wr("leaf", 32'd548, 32'h33, 3'd2, 0, 0);
        expect_wr("jal_link", 32'd540, 32'd48, 3'd2, 0, 0);
        expect_wr("x0_zero", 32'd544, 32'd0, 3'd2, 0, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        finish_test("control");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
